// File: rtl/store_narrow.sv
// store_narrow: narrows a 32-bit register value to byte/half/word and writes it
// into a word-addressed data memory. Sub-word stores read the target word first,
// merge the new lane(s) in, and write the full word back. A flag reports whether
// the narrowed value would not sign-extend back to the original register value.
module store_narrow #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              trunc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t              state_reg, state_next;
  logic [1:0]          size_reg;
  logic [1:0]          lane_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [31:0]         wdata_reg;
  logic [31:0]         merge_reg;
  logic                err_reg;
  logic                trunc_reg;

  logic                req_err;
  logic                req_trunc;
  logic                accept;
  logic [3:0]          lane_hit;
  logic [31:0]         merged;

  assign accept = (state_reg == S_IDLE) && start;

  // Classify the incoming request: alignment/size errors and lost significance.
  always_comb begin
    req_err   = 1'b0;
    req_trunc = 1'b0;
    case (size)
      SZ_BYTE: req_trunc = (wdata[31:8] != {24{wdata[7]}});
      SZ_HALF: begin
        req_err   = addr[0];
        req_trunc = (wdata[31:16] != {16{wdata[15]}});
      end
      SZ_WORD: req_err = (addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
    // An errored request never reports truncation.
    if (req_err) begin
      req_trunc = 1'b0;
    end
  end

  // Per-byte-lane merge of the read word with the narrowed store data.
  // Bytes use the low byte of wdata; halves use the low or high byte of
  // wdata[15:0] depending on which half of the lane pair this byte sits in.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [7:0] lane_src;
      assign lane_hit[gi] = (size_reg == SZ_BYTE) ? (lane_reg == LANE)
                                                  : (lane_reg[1] == LANE[1]);
      assign lane_src = (size_reg == SZ_BYTE) ? wdata_reg[7:0]
                                              : wdata_reg[8*(gi%2)+7 -: 8];
      assign merged[8*gi+7 -: 8] = lane_hit[gi] ? lane_src : mem_rdata[8*gi+7 -: 8];
    end
  endgenerate

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (req_err) begin
            state_next = S_DONE;
          end else if (size == SZ_WORD) begin
            state_next = S_WRITE;
          end else begin
            state_next = S_READ;
          end
        end
      end
      S_READ:  state_next = S_WAIT;
      S_WAIT:  state_next = S_WRITE;
      S_WRITE: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    busy      = (state_reg != S_IDLE);
    done      = (state_reg == S_DONE);
    err       = done && err_reg;
    trunc     = done && trunc_reg;
    mem_rd_en = (state_reg == S_READ);
    mem_wr_en = (state_reg == S_WRITE);
    mem_addr  = (state_reg != S_IDLE) ? addr_reg : '0;
    mem_wdata = mem_wr_en ? merge_reg : 32'h0;
  end

  // State register and request latches; reset abandons any store in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      size_reg  <= 2'b00;
      lane_reg  <= 2'b00;
      addr_reg  <= '0;
      wdata_reg <= 32'h0;
      merge_reg <= 32'h0;
      err_reg   <= 1'b0;
      trunc_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        size_reg  <= size;
        lane_reg  <= addr[1:0];
        addr_reg  <= {addr[ADDR_W-1:2], 2'b00};
        wdata_reg <= wdata;
        // Word stores write wdata as-is; sub-word stores overwrite this in WAIT.
        merge_reg <= wdata;
        err_reg   <= req_err;
        trunc_reg <= req_trunc;
      end
      if (state_reg == S_WAIT) begin
        merge_reg <= merged;
      end
    end
  end

endmodule

// File: tb/tb_store_narrow.sv
// Bench for store_narrow: a behavioural word memory, a scoreboard of expected
// completions pushed at issue and popped on done, a vector table, and a few
// hand-written sequences for reset, held start and busy-time start pulses.
module tb_store_narrow;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err, trunc;
  logic [31:0] mem_addr;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;

  store_narrow #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .trunc(trunc),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre;
    logic [31:0] exp_wdata;
    logic        exp_err;
    logic        exp_trunc;
  } vec_t;

  typedef struct {
    logic        exp_err;
    logic        exp_trunc;
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] exp_waddr;
    logic [31:0] exp_wdata;
    int          exp_lat;
    int          exp_wlat;
    int          exp_acc;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] mem [256];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cycle = 0;
  int          acc_obs = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          wr_cyc = 0;
  logic [31:0] rd_addr_obs = 32'h0;
  logic [31:0] wr_addr_obs = 32'h0;
  logic [31:0] wr_data_obs = 32'h0;
  bit          proto_bad = 1'b0;
  bit          busy_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic clear_obs();
    rd_cnt    = 0;
    wr_cnt    = 0;
    proto_bad = 1'b0;
  endtask

  // Observe the current cycle, serve the memory, then advance one clock.
  // Cycle numbers reported are 1 for the first period after the accept edge.
  task automatic tick();
    logic [31:0] rnext;
    sb_t         e;
    rnext = 32'h0;
    if (!reset) begin
      if (busy && !busy_prev) acc_obs = cycle;
      if (mem_rd_en && mem_wr_en) proto_bad = 1'b1;
      if (!mem_wr_en && mem_wdata != 32'h0) proto_bad = 1'b1;
      if (!busy && mem_addr != 32'h0) proto_bad = 1'b1;
      if (mem_rd_en) begin
        rd_cnt++;
        rd_addr_obs = mem_addr;
        rnext = mem[mem_addr[9:2]];
      end
      if (mem_wr_en) begin
        wr_cnt++;
        wr_addr_obs = mem_addr;
        wr_data_obs = mem_wdata;
        wr_cyc = cycle;
        mem[mem_addr[9:2]] = mem_wdata;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cycle);
        end else begin
          e = sb_q.pop_front();
          $display("store done: err=%0b trunc=%0b wdata=0x%08h at cycle %0d",
                   err, trunc, wr_data_obs, cycle - acc_obs + 1);
          check("err", 64'(err), 64'(e.exp_err));
          check("trunc", 64'(trunc), 64'(e.exp_trunc));
          check("accept_edge", 64'(acc_obs), 64'(e.exp_acc));
          check("done_cycle", 64'(cycle - acc_obs + 1), 64'(e.exp_lat));
          check("rd_count", 64'(rd_cnt), 64'(e.exp_rd));
          check("wr_count", 64'(wr_cnt), 64'(e.exp_wr));
          check("protocol", 64'(proto_bad), 64'd0);
          if (e.exp_rd) check("rd_addr", 64'(rd_addr_obs), 64'(e.exp_waddr));
          if (e.exp_wr) begin
            check("wr_addr", 64'(wr_addr_obs), 64'(e.exp_waddr));
            check("wr_data", 64'(wr_data_obs), 64'(e.exp_wdata));
            check("wr_cycle", 64'(wr_cyc - acc_obs + 1), 64'(e.exp_wlat));
          end
          clear_obs();
        end
      end
      busy_prev = busy;
    end else begin
      busy_prev = 1'b0;
    end
    @(posedge clk);
    #1;
    mem_rdata = rnext;
    cycle++;
  endtask

  function automatic sb_t mk(input vec_t v, input int acc);
    sb_t e;
    bit  sub;
    sub = (v.size != 2'b10);
    e.exp_err   = v.exp_err;
    e.exp_trunc = v.exp_trunc;
    e.exp_rd    = !v.exp_err && sub;
    e.exp_wr    = !v.exp_err;
    e.exp_waddr = {v.addr[31:2], 2'b00};
    e.exp_wdata = v.exp_wdata;
    e.exp_lat   = v.exp_err ? 1 : (sub ? 4 : 2);
    e.exp_wlat  = sub ? 3 : 1;
    e.exp_acc   = acc;
    return e;
  endfunction

  // Wait for idle, preload the target word, drive one start cycle.
  task automatic issue(input vec_t v, input bit push, input bit hold);
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    if (busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
    mem[v.addr[9:2]] = v.pre;
    start = 1'b1;
    size  = v.size;
    addr  = v.addr;
    wdata = v.wdata;
    if (push) sb_q.push_back(mk(v, cycle + 1));
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected %0d completion(s)", sb_q.size());
      sb_q.delete();
    end
  endtask

  vec_t vt[14];
  vec_t v;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    reset = 1'b1; start = 1'b0; size = 2'b00; addr = 32'h0; wdata = 32'h0;
    mem_rdata = 32'h0;

    //           size   addr       wdata         preload       expected write err trunc
    vt[0]  = '{2'b00, 32'h102, 32'h00000011, 32'hAABBCCDD, 32'hAA11CCDD, 1'b0, 1'b0};
    vt[1]  = '{2'b01, 32'h102, 32'hFFFF8001, 32'hAABBCCDD, 32'h8001CCDD, 1'b0, 1'b0};
    vt[2]  = '{2'b01, 32'h102, 32'h00018001, 32'hAABBCCDD, 32'h8001CCDD, 1'b0, 1'b1};
    vt[3]  = '{2'b10, 32'h104, 32'hDEADBEEF, 32'h11111111, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[4]  = '{2'b01, 32'h101, 32'h00001234, 32'hAABBCCDD, 32'h0,        1'b1, 1'b0};
    vt[5]  = '{2'b10, 32'h106, 32'h12345678, 32'hAABBCCDD, 32'h0,        1'b1, 1'b0};
    vt[6]  = '{2'b00, 32'h100, 32'hFFFFFF80, 32'hAABBCCDD, 32'hAABBCC80, 1'b0, 1'b0};
    vt[7]  = '{2'b00, 32'h101, 32'h00000180, 32'hAABBCCDD, 32'hAABB80DD, 1'b0, 1'b1};
    vt[8]  = '{2'b00, 32'h103, 32'h0000007F, 32'hAABBCCDD, 32'h7FBBCCDD, 1'b0, 1'b0};
    vt[9]  = '{2'b01, 32'h100, 32'h00001234, 32'hAABBCCDD, 32'hAABB1234, 1'b0, 1'b0};
    vt[10] = '{2'b11, 32'h108, 32'h00000001, 32'hAABBCCDD, 32'h0,        1'b1, 1'b0};
    vt[11] = '{2'b10, 32'h10C, 32'h80000000, 32'hAABBCCDD, 32'h80000000, 1'b0, 1'b0};
    vt[12] = '{2'b00, 32'h102, 32'h12345678, 32'hAABBCCDD, 32'hAA78CCDD, 1'b0, 1'b1};
    vt[13] = '{2'b01, 32'h103, 32'h00000001, 32'hAABBCCDD, 32'h0,        1'b1, 1'b0};

    repeat (3) tick();
    reset = 1'b0;
    check("reset_ctl", 64'({busy, done, err, trunc, mem_rd_en, mem_wr_en}), 64'd0);
    check("reset_bus", {mem_addr, mem_wdata}, 64'd0);

    for (int i = 0; i < 14; i++) begin
      issue(vt[i], 1'b1, 1'b0);
      wait_done();
    end

    // Reset during WAIT abandons the write; a start right after is accepted.
    v = '{2'b00, 32'h103, 32'h00000055, 32'hAABBCCDD, 32'h0, 1'b0, 1'b0};
    issue(v, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ctl", 64'({busy, done, err, trunc, mem_rd_en, mem_wr_en}), 64'd0);
    check("abort_bus", {mem_addr, mem_wdata}, 64'd0);
    check("abort_wr_count", 64'(wr_cnt), 64'd0);
    clear_obs();
    v = '{2'b00, 32'h111, 32'hFFFFFFEE, 32'h01020304, 32'h0102EE04, 1'b0, 1'b0};
    issue(v, 1'b1, 1'b0);
    wait_done();
    check("abort_mem_kept", 64'(mem[8'h40]), 64'hAABBCCDD);

    // start held through done: the same store repeats, accepted after IDLE.
    v = '{2'b00, 32'h120, 32'h00000042, 32'h99887766, 32'h99887742, 1'b0, 1'b0};
    issue(v, 1'b1, 1'b1);
    wait_done();
    sb_q.push_back(mk(v, cycle + 1));
    tick();
    start = 1'b0;
    wait_done();

    // start pulsed while busy is ignored.
    v = '{2'b00, 32'h131, 32'h00000009, 32'h44332211, 32'h44330911, 1'b0, 1'b0};
    issue(v, 1'b1, 1'b0);
    start = 1'b1; tick();
    start = 1'b0; tick();
    start = 1'b1; tick();
    start = 1'b0;
    wait_done();
    tick();
    tick();
    check("pulse_idle_busy", 64'(busy), 64'd0);
    check("pulse_extra_strobes", 64'(rd_cnt + wr_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
